rng_sampler: RTL and testbench

//  Consumer end of the free-running lcell LFSR noise source. Synchronises the

---
 rtl/rng_sampler.sv | 217 +++++++++++++++++++++
 tb/tb_rng_sampler.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_sampler.sv
// rng_sampler: synchronises the asynchronous LFSR noise bus, health-tests raw bits and packs them into bytes.
// Optional build macro RNG_SAMPLER_DEBIAS_EN adds von Neumann debiasing of raw-bit pairs.
module rng_sampler #(
  parameter int N          = 63,
  parameter int SAMPLE_DIV = 4,
  parameter int REP_LIMIT  = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] rnd_in,
  input  logic         enable,
  input  logic         clear_fail,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         health_fail
);
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int RUN_W = $clog2(REP_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, STALL, FAIL} state_t;
  state_t state, state_nxt;

  logic [N-1:0]     rnd_p0, rnd_p1;
  logic             raw;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [RUN_W-1:0] run_cnt, run_nxt, run_new;
  logic             last_raw, last_nxt;
  logic [7:0]       sh, sh_nxt, data_nxt;
  logic [3:0]       bitcnt, bitcnt_nxt;
  logic             valid_nxt, fail_nxt;
  logic             tick, trip, hs, clr_part, acc_vld, acc_bit;
`ifdef RNG_SAMPLER_DEBIAS_EN
  logic             pair_vld, pair_vld_nxt, pair_bit, pair_bit_nxt;
`endif

  // stage p0/p1: two-flop synchroniser on the asynchronous noise bus
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rnd_p0 <= '0;
      rnd_p1 <= '0;
    end else begin
      rnd_p0 <= rnd_in;
      rnd_p1 <= rnd_p0;
    end
  end

  assign raw = ^rnd_p1;
  assign hs  = out_valid & out_ready;

  always_comb begin
    state_nxt  = state;
    div_nxt    = div_cnt;
    run_nxt    = run_cnt;
    last_nxt   = last_raw;
    sh_nxt     = sh;
    bitcnt_nxt = bitcnt;
    data_nxt   = out_data;
    valid_nxt  = out_valid;
    fail_nxt   = health_fail;
    tick       = 1'b0;
    clr_part   = 1'b0;
    acc_vld    = 1'b0;
    acc_bit    = 1'b0;
    run_new    = run_cnt;
`ifdef RNG_SAMPLER_DEBIAS_EN
    pair_vld_nxt = pair_vld;
    pair_bit_nxt = pair_bit;
`endif

    if (state == COLLECT || state == STALL) begin
      tick    = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
      div_nxt = tick ? '0 : div_cnt + 1'b1;
    end else begin
      div_nxt = '0;
    end

    if (tick)
      run_new = (run_cnt != '0 && raw == last_raw) ? run_cnt + 1'b1 : RUN_W'(1);
    trip = tick && (run_new == RUN_W'(REP_LIMIT));

    // A health trip outranks clear_fail and every other transition
    if (trip) begin
      fail_nxt  = 1'b1;
      valid_nxt = 1'b0;
      run_nxt   = run_new;
      last_nxt  = raw;
      state_nxt = FAIL;
    end else if (clear_fail) begin
      fail_nxt  = 1'b0;
      valid_nxt = 1'b0;
      clr_part  = 1'b1;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          clr_part = 1'b1;
          if (hs)
            valid_nxt = 1'b0;
          if (enable)
            state_nxt = COLLECT;
        end
        FAIL: valid_nxt = 1'b0;
        default: begin
          if (!enable) begin
            clr_part  = 1'b1;
            state_nxt = IDLE;
            if (hs)
              valid_nxt = 1'b0;
          end else begin
            if (tick) begin
              run_nxt  = run_new;
              last_nxt = raw;
            end
            if (state == STALL) begin
              if (hs) begin
                data_nxt   = sh;
                sh_nxt     = '0;
                bitcnt_nxt = '0;
                state_nxt  = COLLECT;
              end
            end else begin
`ifdef RNG_SAMPLER_DEBIAS_EN
              if (tick) begin
                if (!pair_vld) begin
                  pair_vld_nxt = 1'b1;
                  pair_bit_nxt = raw;
                end else begin
                  pair_vld_nxt = 1'b0;
                  pair_bit_nxt = 1'b0;
                  acc_vld      = pair_bit ^ raw;
                  acc_bit      = pair_bit;
                end
              end
`else
              acc_vld = tick;
              acc_bit = raw;
`endif
              if (acc_vld) begin
                sh_nxt     = {acc_bit, sh[7:1]};
                bitcnt_nxt = bitcnt + 1'b1;
              end
              // A completed byte goes straight out if the slot is free or being emptied now
              if (bitcnt_nxt == 4'd8) begin
                if (!out_valid || hs) begin
                  data_nxt   = sh_nxt;
                  valid_nxt  = 1'b1;
                  sh_nxt     = '0;
                  bitcnt_nxt = '0;
                end else begin
                  state_nxt = STALL;
                end
              end else if (hs) begin
                valid_nxt = 1'b0;
              end
            end
          end
        end
      endcase
    end

    if (clr_part) begin
      div_nxt    = '0;
      run_nxt    = '0;
      last_nxt   = 1'b0;
      sh_nxt     = '0;
      bitcnt_nxt = '0;
`ifdef RNG_SAMPLER_DEBIAS_EN
      pair_vld_nxt = 1'b0;
      pair_bit_nxt = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // stage p2: collection counters, shift register and output byte
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt     <= '0;
      run_cnt     <= '0;
      last_raw    <= 1'b0;
      sh          <= '0;
      bitcnt      <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      run_cnt     <= run_nxt;
      last_raw    <= last_nxt;
      sh          <= sh_nxt;
      bitcnt      <= bitcnt_nxt;
      out_data    <= data_nxt;
      out_valid   <= valid_nxt;
      health_fail <= fail_nxt;
    end
  end

`ifdef RNG_SAMPLER_DEBIAS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pair_vld <= 1'b0;
      pair_bit <= 1'b0;
    end else begin
      pair_vld <= pair_vld_nxt;
      pair_bit <= pair_bit_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_rng_sampler.sv
// Testbench for rng_sampler: random and patterned noise checked against a queue-based reference model.
module tb_rng_sampler;
  localparam int N          = 63;
  localparam int SAMPLE_DIV = 4;
  localparam int REP_LIMIT  = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] rnd_in = '0;
  logic         enable = 1'b0;
  logic         clear_fail = 1'b0;
  logic         out_ready = 1'b0;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         health_fail;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rng_sampler #(.N(N), .SAMPLE_DIV(SAMPLE_DIV), .REP_LIMIT(REP_LIMIT)) dut (
    .clk(clk), .reset_n(reset_n), .rnd_in(rnd_in), .enable(enable), .clear_fail(clear_fail),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .health_fail(health_fail)
  );

  // Reference model: modes, a queue of accepted bits, and the parity history of the bus
  localparam int MI = 0, MR = 1, MS = 2, MF = 3;
  int         m_mode = MI;
  int         m_div = 0, m_run = 0;
  bit         m_last = 1'b0;
  bit         bitq[$];
  logic [7:0] m_data = '0;
  bit         m_valid = 1'b0, m_hf = 1'b0;
  bit         p1 = 1'b0, p2 = 1'b0;
`ifdef RNG_SAMPLER_DEBIAS_EN
  bit         m_pair_have = 1'b0, m_pair_bit = 1'b0;
`endif

  function automatic logic [7:0] pack_q();
    logic [7:0] v = '0;
    for (int i = 0; i < 8 && i < bitq.size(); i++) v[i] = bitq[i];
    return v;
  endfunction

  task automatic model_clear_partial();
    m_div = 0; m_run = 0; m_last = 1'b0; bitq.delete();
`ifdef RNG_SAMPLER_DEBIAS_EN
    m_pair_have = 1'b0; m_pair_bit = 1'b0;
`endif
  endtask

  task automatic model_edge();
    bit raw, hs, tick;
    int run_new;
    raw = p2; p2 = p1; p1 = ^rnd_in;
    hs = m_valid && out_ready;
    tick = 1'b0;
    if (m_mode == MR || m_mode == MS) begin
      tick = (m_div == SAMPLE_DIV - 1);
      m_div = tick ? 0 : m_div + 1;
    end
    run_new = m_run;
    if (tick) run_new = (m_run > 0 && raw == m_last) ? m_run + 1 : 1;
    if (tick && run_new == REP_LIMIT) begin
      m_hf = 1'b1; m_valid = 1'b0; m_mode = MF;
      return;
    end
    if (clear_fail) begin
      m_hf = 1'b0; m_valid = 1'b0; m_mode = MI; model_clear_partial();
      return;
    end
    if (m_mode == MF) return;
    if (m_mode == MI) begin
      if (hs) m_valid = 1'b0;
      if (enable) m_mode = MR;
      return;
    end
    if (!enable) begin
      m_mode = MI; model_clear_partial();
      if (hs) m_valid = 1'b0;
      return;
    end
    if (tick) begin m_run = run_new; m_last = raw; end
    if (m_mode == MS) begin
      if (hs) begin m_data = pack_q(); bitq.delete(); m_mode = MR; end
      return;
    end
    if (tick) begin
`ifdef RNG_SAMPLER_DEBIAS_EN
      if (!m_pair_have) begin
        m_pair_have = 1'b1; m_pair_bit = raw;
      end else begin
        m_pair_have = 1'b0;
        if (m_pair_bit != raw) bitq.push_back(m_pair_bit);
      end
`else
      bitq.push_back(raw);
`endif
    end
    if (bitq.size() == 8) begin
      if (!m_valid || hs) begin m_data = pack_q(); m_valid = 1'b1; bitq.delete(); end
      else m_mode = MS;
    end else if (hs) begin
      m_valid = 1'b0;
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = MI; m_data = '0; m_valid = 1'b0; m_hf = 1'b0; p1 = 1'b0; p2 = 1'b0;
      model_clear_partial();
    end else begin
      model_edge();
    end
  end

  // Stimulus helpers
  int blk_cyc = 0, blk_rep = 0;
  bit blk_par = 1'b0;

  function automatic logic [N-1:0] rnd_par(input bit p);
    logic [63:0]  w;
    logic [N-1:0] r;
    w = {$urandom, $urandom};
    r = w[N-1:0];
    if ((^r) != p) r[0] = ~r[0];
    return r;
  endfunction

  // Parity held for SAMPLE_DIV cycles per block, never more than 3 equal blocks in a row
  task automatic next_blk();
    bit nb;
    if (blk_cyc % SAMPLE_DIV == 0) begin
      nb = 1'($urandom_range(0, 1));
      if (blk_rep >= 3 && nb == blk_par) nb = ~blk_par;
      blk_rep = (nb == blk_par) ? blk_rep + 1 : 1;
      blk_par = nb;
    end
    blk_cyc++;
    rnd_in = rnd_par(blk_par);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; enable = 1'b0; clear_fail = 1'b0; out_ready = 1'b0; rnd_in = '0;
    @(negedge clk);
    reset_n = 1'b1;
    blk_cyc = 0; blk_rep = 0;
  endtask

  task automatic run_pattern(input logic [15:0] pat, input int plen, input logic [7:0] expv, input string name);
    bit got = 1'b0;
    int idx;
    enable = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 300 && !got; c++) begin
      idx = (c / SAMPLE_DIV) % plen;
      rnd_in = rnd_par(pat[idx[3:0]]);
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({out_valid, out_data, health_fail} !== {m_valid, m_data, m_hf}) begin
        n_fail++;
        $display("FAIL %s model c%0d: got v=%0b d=%02h hf=%0b, want v=%0b d=%02h hf=%0b", name, c, out_valid, out_data, health_fail, m_valid, m_data, m_hf);
      end
      if (out_valid === 1'b1) begin
        got = 1'b1;
        n_checks++;
        if (out_data !== expv) begin
          n_fail++;
          $display("FAIL %s byte: got %02h, want %02h", name, out_data, expv);
        end
      end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: got no byte, want %02h", name, expv);
    end
    n_checks++;
    if (health_fail !== 1'b0) begin
      n_fail++;
      $display("FAIL %s health: got %0b, want 0", name, health_fail);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %02h, want 00", out_data); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b, want 0", out_valid); end
    n_checks++;
    if (health_fail !== 1'b0) begin n_fail++; $display("FAIL reset_health: got %0b, want 0", health_fail); end
    reset_n = 1'b1;
  endtask

  task automatic test_health_const();
    bit seen_valid = 1'b0;
    int hf_cyc = -1;
    do_reset();
    rnd_in = '1; enable = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({out_valid, out_data, health_fail} !== {m_valid, m_data, m_hf}) begin
        n_fail++;
        $display("FAIL const model c%0d: got v=%0b d=%02h hf=%0b, want v=%0b d=%02h hf=%0b", c, out_valid, out_data, health_fail, m_valid, m_data, m_hf);
      end
      if (out_valid === 1'b1) seen_valid = 1'b1;
      if (health_fail === 1'b1 && hf_cyc < 0) hf_cyc = c;
    end
    n_checks++;
    if (hf_cyc < 0 || hf_cyc > 35) begin n_fail++; $display("FAIL const_trip: got cycle %0d, want 1..35", hf_cyc); end
    n_checks++;
    if (seen_valid) begin n_fail++; $display("FAIL const_valid: got out_valid=1, want never"); end
  endtask

  task automatic test_clear_fail();
    int bytes = 0;
    @(negedge clk);
    enable = 1'b0; clear_fail = 1'b1;
    @(negedge clk);
    clear_fail = 1'b0;
    n_checks++;
    if (health_fail !== 1'b0) begin n_fail++; $display("FAIL clear_health: got %0b, want 0", health_fail); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_valid: got %0b, want 0", out_valid); end
    blk_cyc = 0; blk_rep = 0;
    for (int c = 0; c < 410; c++) begin
      if (c == 10) begin enable = 1'b1; out_ready = 1'b1; end
      next_blk();
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({out_valid, out_data, health_fail} !== {m_valid, m_data, m_hf}) begin
        n_fail++;
        $display("FAIL resume model c%0d: got v=%0b d=%02h hf=%0b, want v=%0b d=%02h hf=%0b", c, out_valid, out_data, health_fail, m_valid, m_data, m_hf);
      end
      if (out_valid === 1'b1) bytes++;
    end
    n_checks++;
    if (bytes == 0) begin n_fail++; $display("FAIL resume_bytes: got 0 bytes, want >0"); end
  endtask

  task automatic test_stall();
    logic [7:0] first_b = '0, second_b;
    bit got_first = 1'b0;
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 1500 && m_mode != MS; c++) begin
      next_blk();
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({out_valid, out_data, health_fail} !== {m_valid, m_data, m_hf}) begin
        n_fail++;
        $display("FAIL stall model c%0d: got v=%0b d=%02h hf=%0b, want v=%0b d=%02h hf=%0b", c, out_valid, out_data, health_fail, m_valid, m_data, m_hf);
      end
      if (m_valid && !got_first) begin got_first = 1'b1; first_b = m_data; end
    end
    if (m_mode != MS) begin
      n_checks++; n_fail++;
      $display("FAIL stall_reach: got no second byte, want stall within 1500 cycles");
    end
    repeat (16 * SAMPLE_DIV) begin
      next_blk();
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({out_valid, out_data, health_fail} !== {m_valid, m_data, m_hf}) begin
        n_fail++;
        $display("FAIL stall_hold model: got v=%0b d=%02h hf=%0b, want v=%0b d=%02h hf=%0b", out_valid, out_data, health_fail, m_valid, m_data, m_hf);
      end
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== first_b) begin
      n_fail++;
      $display("FAIL stall_first: got v=%0b d=%02h, want v=1 d=%02h", out_valid, out_data, first_b);
    end
    second_b = pack_q();
    next_blk();
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== second_b) begin
      n_fail++;
      $display("FAIL stall_second: got v=%0b d=%02h, want v=1 d=%02h", out_valid, out_data, second_b);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      enable     = ($urandom_range(0, 99) != 0);
      out_ready  = 1'($urandom_range(0, 1));
      clear_fail = (m_hf && !clear_fail) || ($urandom_range(0, 199) == 0);
      rnd_in     = rnd_par(1'($urandom_range(0, 1)));
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({out_valid, out_data, health_fail} !== {m_valid, m_data, m_hf}) begin
        n_fail++;
        $display("FAIL random model c%0d: got v=%0b d=%02h hf=%0b, want v=%0b d=%02h hf=%0b", c, out_valid, out_data, health_fail, m_valid, m_data, m_hf);
      end
    end
    clear_fail = 1'b0;
  endtask

  task automatic test_patterns();
`ifdef RNG_SAMPLER_DEBIAS_EN
    do_reset(); run_pattern(16'b01, 2, 8'hFF, "pat_10");
    do_reset(); run_pattern(16'b10, 2, 8'h00, "pat_01");
    do_reset(); run_pattern(16'b1001, 4, 8'h55, "pat_1001");
`else
    do_reset(); run_pattern(16'h004B, 8, 8'h4B, "pat_4b");
    do_reset(); run_pattern(16'b10, 2, 8'hAA, "pat_01");
    do_reset(); run_pattern(16'b0011, 4, 8'h33, "pat_1100");
`endif
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 800 && !hit; c++) begin
      next_blk();
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({out_valid, out_data, health_fail} !== {m_valid, m_data, m_hf}) begin
        n_fail++;
        $display("FAIL midrst model c%0d: got v=%0b d=%02h hf=%0b, want v=%0b d=%02h hf=%0b", c, out_valid, out_data, health_fail, m_valid, m_data, m_hf);
      end
      if (m_valid && bitq.size() == 5) hit = 1'b1;
    end
    if (!hit) begin
      n_checks++; n_fail++;
      $display("FAIL midrst_reach: got no byte plus 5 bits, want within 800 cycles");
    end
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_data, health_fail} !== 10'b0) begin
      n_fail++;
      $display("FAIL midrst_async: got v=%0b d=%02h hf=%0b, want all 0", out_valid, out_data, health_fail);
    end
    @(negedge clk);
    enable = 1'b0; out_ready = 1'b0; reset_n = 1'b1;
`ifdef RNG_SAMPLER_DEBIAS_EN
    run_pattern(16'b01, 2, 8'hFF, "midrst_fresh");
`else
    run_pattern(16'h004B, 8, 8'h4B, "midrst_fresh");
`endif
  endtask

  initial begin
    test_reset();
    test_health_const();
    test_clear_fail();
    test_patterns();
    test_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
